// File: rtl/delay_if.sv
// Data bus of a delay line: sample in (D), delayed sample out (Q) and the primed flag.
// The producer holds the master side; the delay line itself holds the slave side.
interface delay_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             primed;

    modport master (output D, input Q, input primed);
    modport slave  (input D, output Q, output primed);
endinterface

// File: rtl/delay.sv
// Fixed-latency pipeline alignment element: Q reproduces D exactly DEPTH rising edges later.
// Gapless shift register with a saturating fill counter that raises primed once the line holds real data.
module delay #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic    clk,
    input logic    reset,
    delay_if.slave bus
);
    // Out-of-range latencies are rejected at elaboration rather than silently clamped.
    if (DEPTH < 1 || DEPTH > 64) begin : g_depth_check
        $error("delay: DEPTH must be in 1..64");
    end

    localparam int               CNT_W   = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             primed_q;

    always_comb begin
        cnt_next = cnt;
        if (cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the stages are individual flops, not a RAM, so resetting the whole array is cheap and legal.
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= RESET_VAL;
            end
            cnt      <= '0;
            primed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage read its neighbour's old value, so the loop order is irrelevant.
            stage[0] <= bus.D;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
            cnt      <= cnt_next;
            primed_q <= (cnt_next == CNT_MAX);
        end
    end

    assign bus.Q      = stage[DEPTH-1];
    assign bus.primed = primed_q;
endmodule

// File: tb/tb_delay.sv
// Self-checking bench for the delay line: DEPTH=1, a chained pair, DEPTH=4 and a RESET_VAL override.
// Streams use a scoreboard queue of expected outputs; fixed corner cases use literal vector tables.
module tb_delay;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    delay_if #(.WIDTH(8)) if_a  ();
    delay_if #(.WIDTH(8)) if_c1 ();
    delay_if #(.WIDTH(8)) if_c2 ();
    delay_if #(.WIDTH(8)) if_d  ();
    delay_if #(.WIDTH(8)) if_r  ();

    assign if_c2.D = if_c1.Q;

    delay #(.WIDTH(8), .DEPTH(1)) u_a  (.clk(clk), .reset(reset), .bus(if_a));
    delay #(.WIDTH(8), .DEPTH(1)) u_c1 (.clk(clk), .reset(reset), .bus(if_c1));
    delay #(.WIDTH(8), .DEPTH(1)) u_c2 (.clk(clk), .reset(reset), .bus(if_c2));
    delay #(.WIDTH(8), .DEPTH(4)) u_d  (.clk(clk), .reset(reset), .bus(if_d));
    delay #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C)) u_r (.clk(clk), .reset(reset), .bus(if_r));

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] q;
        logic       primed;
    } vec_t;

    vec_t       deep_tbl   [8];
    vec_t       refill_tbl [6];
    logic [7:0] sb [$];
    logic [7:0] exp_q;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        deep_tbl[0] = '{8'hA0, 8'h00, 1'b0};
        deep_tbl[1] = '{8'hA1, 8'h00, 1'b0};
        deep_tbl[2] = '{8'hA2, 8'h00, 1'b0};
        deep_tbl[3] = '{8'hA3, 8'hA0, 1'b1};
        deep_tbl[4] = '{8'hA4, 8'hA1, 1'b1};
        deep_tbl[5] = '{8'hA5, 8'hA2, 1'b1};
        deep_tbl[6] = '{8'hA6, 8'hA3, 1'b1};
        deep_tbl[7] = '{8'hA7, 8'hA4, 1'b1};

        refill_tbl[0] = '{8'h55, 8'h00, 1'b0};
        refill_tbl[1] = '{8'h66, 8'h00, 1'b0};
        refill_tbl[2] = '{8'h77, 8'h00, 1'b0};
        refill_tbl[3] = '{8'h88, 8'h55, 1'b1};
        refill_tbl[4] = '{8'h99, 8'h66, 1'b1};
        refill_tbl[5] = '{8'hAA, 8'h77, 1'b1};

        reset   = 1'b1;
        if_a.D  = 8'h00;
        if_c1.D = 8'h00;
        if_d.D  = 8'h00;
        if_r.D  = 8'h00;
        tick();
        tick();

        check("rst_a_q",      if_a.Q,           8'h00);
        check("rst_a_primed", 8'(if_a.primed),  8'h00);
        check("rst_d_q",      if_d.Q,           8'h00);
        check("rst_d_primed", 8'(if_d.primed),  8'h00);
        check("rst_r_q",      if_r.Q,           8'h3C);
        check("rst_r_primed", 8'(if_r.primed),  8'h00);
        reset = 1'b0;

        // Basic DEPTH=1 latency.
        sb = {};
        for (int i = 0; i < 10; i++) begin
            if_a.D = 8'(i);
            sb.push_back(8'(i));
            tick();
            exp_q = sb.pop_front();
            check($sformatf("basic_q[%0d]", i), if_a.Q, exp_q);
            check($sformatf("basic_primed[%0d]", i), 8'(if_a.primed), 8'h01);
        end

        // Two chained DEPTH=1 instances.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb = {8'h00};
        for (int i = 0; i < 10; i++) begin
            if_c1.D = 8'(i);
            sb.push_back(8'(i));
            tick();
            check($sformatf("chain_mid[%0d]", i), if_c1.Q, 8'(i));
            exp_q = sb.pop_front();
            check($sformatf("chain_q[%0d]", i), if_c2.Q, exp_q);
        end

        // Deep line, DEPTH=4.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if_d.D = deep_tbl[i].d;
            tick();
            check($sformatf("deep_q[%0d]", i), if_d.Q, deep_tbl[i].q);
            check($sformatf("deep_primed[%0d]", i), 8'(if_d.primed), 8'(deep_tbl[i].primed));
        end

        // Fill, asynchronous-looking reset pulse between edges, then a real reset edge.
        for (int i = 0; i < 4; i++) begin
            if_d.D = 8'h11 + 8'(i);
            tick();
        end
        check("fill_q",      if_d.Q,          8'h11);
        check("fill_primed", 8'(if_d.primed), 8'h01);

        if_d.D = 8'h15;
        reset  = 1'b1;
        #2;
        reset  = 1'b0;
        #1;
        check("pulse_q",      if_d.Q,          8'h11);
        check("pulse_primed", 8'(if_d.primed), 8'h01);
        tick();
        check("after_pulse_q", if_d.Q, 8'h12);

        reset  = 1'b1;
        if_d.D = 8'hFF;
        tick();
        reset  = 1'b0;
        check("sync_rst_q",      if_d.Q,          8'h00);
        check("sync_rst_primed", 8'(if_d.primed), 8'h00);

        // Refill after reset.
        for (int i = 0; i < 6; i++) begin
            if_d.D = refill_tbl[i].d;
            tick();
            check($sformatf("refill_q[%0d]", i), if_d.Q, refill_tbl[i].q);
            check($sformatf("refill_primed[%0d]", i), 8'(if_d.primed), 8'(refill_tbl[i].primed));
        end

        // RESET_VAL override.
        reset  = 1'b1;
        if_r.D = 8'hEE;
        tick();
        reset  = 1'b0;
        check("ovr_rst_q", if_r.Q, 8'h3C);
        sb = {8'h3C, 8'h3C, 8'h3C};
        for (int i = 0; i < 6; i++) begin
            if_r.D = 8'h01 + 8'(i);
            sb.push_back(8'h01 + 8'(i));
            tick();
            exp_q = sb.pop_front();
            check($sformatf("ovr_q[%0d]", i), if_r.Q, exp_q);
            check($sformatf("ovr_primed[%0d]", i), 8'(if_r.primed), (i >= 3) ? 8'h01 : 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/delay.md
Name: delay

Overview:
- Parameterised synchronous delay line: output `Q` reproduces input `D` exactly `DEPTH` rising clock edges later.
- Used as a pipeline-alignment element. Instances chain directly (`Q` of one into `D` of the next), and the latencies add.
- Default configuration is a single 8-bit register stage.

Parameters:
- `WIDTH`, 8: data bit width of `D` and `Q`.
- `DEPTH`, 1: number of register stages, i.e. latency in clock cycles. Legal range is 1 to 64; any value outside it must fail elaboration.
- `RESET_VAL`, 0: value (`WIDTH` bits) loaded into every stage on reset.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high reset.
- `D`: input, `WIDTH` bits. Data in, sampled every rising edge.
- `Q`: output, `WIDTH` bits. Data out, driven from the last stage register.
- `primed`: output, 1 bit. High once `DEPTH` valid samples have propagated since the last reset. May be left unconnected.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Storage: `DEPTH` stages, `stage[0]` to `stage[DEPTH-1]`, each `WIDTH` bits.
- Output path:
  - `Q` = `stage[DEPTH-1]`, registered.
  - No combinational path from `D` to `Q`.
- Rising edge with `reset` = 0:
  - `stage[0]` <= `D`.
  - `stage[k]` <= `stage[k-1]` for k = 1 .. `DEPTH-1`.
  - Every edge shifts; there is no enable or stall.
- Latency: a value presented on `D` before rising edge n appears on `Q` immediately after edge n+`DEPTH`-1.
  - With `DEPTH` = 1, `Q` follows `D` one edge later.
  - Two chained `DEPTH` = 1 instances give 2-cycle latency.
- Throughput: one sample per clock. The line is gapless, with no bubbles or reordering.
- Rising edge with `reset` = 1:
  - All stages <= `RESET_VAL`; `D` is ignored that cycle.
  - `primed` <= 0.
  - Asserting reset mid-stream discards all in-flight data.
  - Reset has no effect between edges (synchronous only).
- `primed` counter:
  - Internal counter, width ceil(log2(`DEPTH`+1)), cleared by reset.
  - Increments on each non-reset edge and saturates at `DEPTH`.
  - `primed` = 1 when the counter equals `DEPTH`; registered output.
  - On the first edge after reset deasserts, the counter becomes 1.
- Power-up:
  - No initial value is required for stages or counter.
  - `Q` and `primed` are undefined until a reset edge or until `DEPTH` shifting edges have occurred.
  - A design must either reset the block or ignore `Q` for the first `DEPTH` cycles.
- Data is passed bit-exact: no arithmetic, truncation or sign handling.

Test Plan:
- Basic latency: `WIDTH`=8, `DEPTH`=1, `reset`=0 throughout. Apply `D` = 0,1,...,9, each held across one rising edge. After edge k, `Q` = k-1 (k counted from 1), so `Q` = 9 after the 10th edge.
- Chained pair: two `DEPTH`=1 instances in series with the same stimulus of 0..9. The intermediate net equals the value applied one edge earlier. The final `Q` equals the value applied two edges earlier: `Q` = 0 after edge 2, and 8 after edge 10.
- Deep line: `DEPTH`=4, `D` = 0xA0+i on cycle i. `Q` = 0xA0 after edge 4, then increments by 1 per edge. `primed` rises after edge 4.
- Synchronous reset:
  - Fill `DEPTH`=4 with 0x11..0x14, then hold `reset`=1 for one edge while `D`=0xFF.
  - After that edge, `Q`=`RESET_VAL`(0) and `primed`=0.
  - Pulse `reset` high between edges without an edge occurring: no change.
- Post-reset refill: after reset, feed 0x55, 0x66, ... `Q` stays 0 for 3 edges, then shows 0x55 after the 4th edge. `primed`=1 from the 4th edge onward.
- `RESET_VAL` override: `RESET_VAL`=0x3C. Reset, then observe `Q`=0x3C for `DEPTH`-1 edges before data emerges.
